wb_aperture_mux: RTL and testbench

- Parametrised Wishbone slave-select and response-return block for the AL4S3B FPGA aperture. It decodes the bridge address into NUM_CH channel selects and muxes the read data and ack back to the bridge.
- Replaces the hand-written per-IP decode in the FPGA IP top level.
- Adds a bus watchdog: any access that no slave acks within TIMEOUT cycles is terminated with DEFAULT_READ_VALUE, and the failing address is captured for firmware.

---
 rtl/wb_aperture_mux_pkg.sv | 18 +
 rtl/wb_aperture_mux_if.sv | 30 +++
 rtl/wb_aperture_mux_watchdog.sv | 89 ++++++++
 rtl/wb_aperture_mux.sv | 90 +++++++++
 tb/tb_wb_aperture_mux.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_aperture_mux_pkg.sv
// Shared types and constants for the Wishbone aperture mux and its bus watchdog.
package wb_aperture_pkg;

   localparam int unsigned ERR_CNT_W     = 8;
   localparam logic [31:0] DEFAULT_RDATA = 32'hBADF_ABAC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      TERM = 2'd2
   } wd_state_e;

   // Error counter step that sticks at all-ones.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == '1) ? v : v + ERR_CNT_W'(1);
   endfunction

endpackage

// File: rtl/wb_aperture_mux_if.sv
// Bridge-side and channel-side Wishbone signals of the aperture mux.
interface wb_aperture_mux_if #(
   parameter int unsigned APERWIDTH = 17,
   parameter int unsigned NUM_CH    = 4
);
   logic [APERWIDTH-1:0] WBs_ADR_i;
   logic                 WBs_CYC_i;
   logic                 WBs_STB_i;
   logic                 WBs_WE_i;
   logic                 WBs_RD_i;
   logic [3:0]           WBs_BYTE_STB_i;
   logic [31:0]          WBs_DAT_o;
   logic                 WBs_ACK_o;
   logic [NUM_CH-1:0]    S_CYC_o;
   logic [NUM_CH*32-1:0] S_DAT_i;
   logic [NUM_CH-1:0]    S_ACK_i;

   // Bridge plus peripherals: drives requests and slave responses.
   modport master (
      output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_RD_i, WBs_BYTE_STB_i,
      output S_DAT_i, S_ACK_i,
      input  WBs_DAT_o, WBs_ACK_o, S_CYC_o
   );

   modport slave (
      input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_RD_i, WBs_BYTE_STB_i,
      input  S_DAT_i, S_ACK_i,
      output WBs_DAT_o, WBs_ACK_o, S_CYC_o
   );
endinterface

// File: rtl/wb_aperture_mux_watchdog.sv
// Bus watchdog: terminates accesses nobody acks and records the failing address.
// Optional ERR_INTR output under WB_APERTURE_MUX_ERR_INTR_EN.
module wb_bus_watchdog
   import wb_aperture_pkg::*;
#(
   parameter int unsigned ADR_W   = 17,
   parameter int unsigned TIMEOUT = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req,
   input  logic                 cyc,
   input  logic                 slave_ack,
   input  logic [ADR_W-1:0]     adr,
   input  logic                 err_clr,
   output logic                 term,
   output logic                 err_valid,
   output logic [ADR_W-1:0]     err_adr,
   output logic [ERR_CNT_W-1:0] err_cnt
`ifdef WB_APERTURE_MUX_ERR_INTR_EN
   ,
   output logic                 err_intr
`endif
);

   localparam int unsigned    CNT_W    = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   wd_state_e        state;
   logic [CNT_W-1:0] cnt;

   // Access tracking: a slave ack or a dropped cycle ends the wait quietly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) cnt <= '0;
               if (req && !slave_ack) state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt + CNT_W'(1);
               if (slave_ack || !cyc) state <= IDLE;
               else if (cnt == CNT_LAST) state <= TERM;
            end
            TERM:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign term = (state == TERM);

   // First-error address capture; a timeout coinciding with a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_valid <= 1'b0;
         err_adr   <= '0;
         err_cnt   <= '0;
      end else if (state == TERM) begin
         if (err_clr) begin
            err_valid <= 1'b1;
            err_adr   <= adr;
            err_cnt   <= ERR_CNT_W'(1);
         end else begin
            if (!err_valid) begin
               err_valid <= 1'b1;
               err_adr   <= adr;
            end
            err_cnt <= sat_inc(err_cnt);
         end
      end else if (err_clr) begin
         err_valid <= 1'b0;
         err_adr   <= '0;
         err_cnt   <= '0;
      end
   end

`ifdef WB_APERTURE_MUX_ERR_INTR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         err_intr <= 1'b0;
      else if (state == TERM && !err_valid) err_intr <= 1'b1;
      else if (err_clr)                   err_intr <= 1'b0;
   end
`endif

endmodule

// File: rtl/wb_aperture_mux.sv
// Wishbone aperture decode, read-data/ack return and bus watchdog for the FPGA IP top.
// Define WB_APERTURE_MUX_ERR_INTR_EN to add the ERR_INTR_o interrupt level.
module wb_aperture_mux
   import wb_aperture_pkg::*;
#(
   parameter int unsigned                    APERWIDTH          = 17,
   parameter int unsigned                    APERSIZE           = 10,
   parameter int unsigned                    NUM_CH             = 4,
   parameter logic [NUM_CH*APERWIDTH-1:0]    CH_BASE_ADDR       = {17'h12000, 17'h02000, 17'h01000, 17'h00000},
   parameter logic [NUM_CH-1:0]              CH_WR_BYTE0_ONLY   = 4'b0110,
   parameter int unsigned                    TIMEOUT            = 7,
   parameter logic [31:0]                    DEFAULT_READ_VALUE = DEFAULT_RDATA
) (
   input  logic                  WBs_CLK_i,
   input  logic                  WBs_RST_n_i,
   wb_aperture_mux_if.slave      bus,
   input  logic                  ERR_CLR_i,
   output logic                  ERR_VALID_o,
   output logic [APERWIDTH-1:0]  ERR_ADR_o,
   output logic [ERR_CNT_W-1:0]  ERR_CNT_o
`ifdef WB_APERTURE_MUX_ERR_INTR_EN
   ,
   output logic                  ERR_INTR_o
`endif
);

   localparam int unsigned DEC_LSB = APERSIZE + 2;
   localparam int unsigned DEC_W   = APERWIDTH - DEC_LSB;

   logic [NUM_CH-1:0] hit_raw;
   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] qual;
   logic [NUM_CH-1:0] s_cyc;
   logic [31:0]       rdata;
   logic              slave_ack;
   logic              term;

   // Channel decode on the high address bits, per-channel access qualification.
   always_comb begin
      hit_raw = '0;
      qual    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         hit_raw[i] = (bus.WBs_ADR_i[APERWIDTH-1:DEC_LSB] ==
                       CH_BASE_ADDR[i*APERWIDTH+DEC_LSB +: DEC_W]);
         qual[i]    = bus.WBs_RD_i |
                      (bus.WBs_WE_i & (~CH_WR_BYTE0_ONLY[i] | bus.WBs_BYTE_STB_i[0]));
      end
   end

   // Overlapping apertures resolve to the lowest channel index.
   assign hit = hit_raw & ~(hit_raw - NUM_CH'(1));

   assign s_cyc = hit & qual & {NUM_CH{bus.WBs_CYC_i & ~term & WBs_RST_n_i}};

   assign slave_ack = |(bus.S_ACK_i & s_cyc);

   always_comb begin
      rdata = DEFAULT_READ_VALUE;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (hit[i]) rdata = bus.S_DAT_i[i*32 +: 32];
      end
      if (term) rdata = DEFAULT_READ_VALUE;
   end

   assign bus.S_CYC_o   = s_cyc;
   assign bus.WBs_DAT_o = rdata;
   assign bus.WBs_ACK_o = (slave_ack | term) & WBs_RST_n_i;

   wb_bus_watchdog #(
      .ADR_W   (APERWIDTH),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (WBs_CLK_i),
      .rst_n     (WBs_RST_n_i),
      .req       (bus.WBs_CYC_i & bus.WBs_STB_i),
      .cyc       (bus.WBs_CYC_i),
      .slave_ack (slave_ack),
      .adr       (bus.WBs_ADR_i),
      .err_clr   (ERR_CLR_i),
      .term      (term),
      .err_valid (ERR_VALID_o),
      .err_adr   (ERR_ADR_o),
      .err_cnt   (ERR_CNT_o)
`ifdef WB_APERTURE_MUX_ERR_INTR_EN
      ,
      .err_intr  (ERR_INTR_o)
`endif
   );

endmodule

// File: tb/tb_wb_aperture_mux.sv
// Self-checking bench for wb_aperture_mux: directed plan steps plus randomized accesses.
`timescale 1ns/1ps
module tb_wb_aperture_mux;

   localparam int unsigned AW   = 17;
   localparam int unsigned NCH  = 4;
   localparam int          TO   = 7;
   localparam logic [31:0] DFLT = 32'hBADFABAC;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic err_clr = 1'b0;
   logic          err_valid;
   logic [AW-1:0] err_adr;
   logic [7:0]    err_cnt;
`ifdef WB_APERTURE_MUX_ERR_INTR_EN
   logic          err_intr;
   bit            m_intr;
`endif

   int checks = 0;
   int fails  = 0;

   // Reference view of the aperture map and error capture state
   logic [AW-1:0] base [NCH] = '{17'h00000, 17'h01000, 17'h02000, 17'h12000};
   bit            b0only [NCH] = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic [31:0]   sdat [NCH];
   bit            m_valid;
   logic [AW-1:0] m_adr;
   int            m_cnt;

   wb_aperture_mux_if #(.APERWIDTH(AW), .NUM_CH(NCH)) bus ();

   wb_aperture_mux dut (
      .WBs_CLK_i   (clk),
      .WBs_RST_n_i (rst_n),
      .bus         (bus.slave),
      .ERR_CLR_i   (err_clr),
      .ERR_VALID_o (err_valid),
      .ERR_ADR_o   (err_adr),
      .ERR_CNT_o   (err_cnt)
`ifdef WB_APERTURE_MUX_ERR_INTR_EN
      ,
      .ERR_INTR_o  (err_intr)
`endif
   );

   always #5 clk = ~clk;

   assign bus.S_DAT_i = {sdat[3], sdat[2], sdat[1], sdat[0]};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_ch(input logic [AW-1:0] a);
      for (int i = 0; i < NCH; i++)
         if (a[AW-1:12] == base[i][AW-1:12]) return i;
      return -1;
   endfunction

   task automatic chk_err(input string tag);
      chk({tag, "/err_valid"}, 64'(err_valid), 64'(m_valid));
      chk({tag, "/err_adr"},   64'(err_adr),   64'(m_adr));
      chk({tag, "/err_cnt"},   64'(err_cnt),   64'(m_cnt));
`ifdef WB_APERTURE_MUX_ERR_INTR_EN
      chk({tag, "/err_intr"},  64'(err_intr),  64'(m_intr));
`endif
   endtask

   // One bridge access; ack_dly is the cycle (0 = request cycle) the addressed slave acks, -1 never.
   task automatic run_access(input logic [AW-1:0] a, input bit we, input logic [3:0] bs,
                             input int ack_dly, input bit clr_term, input string tag);
      int             ch     = model_ch(a);
      bit             sel    = (ch >= 0) && (!we || !b0only[ch] || bs[0]);
      bit             slv    = sel && (ack_dly >= 0) && (ack_dly <= TO);
      int             ack_at = slv ? ack_dly : TO + 1;
      logic [NCH-1:0] exp_cyc = sel ? (NCH'(1) << ch) : '0;
      logic [31:0]    exp_dat = slv ? sdat[ch] : DFLT;
      logic [NCH-1:0] noise;
      @(posedge clk); #1;
      bus.WBs_ADR_i      = a;
      bus.WBs_WE_i       = we;
      bus.WBs_RD_i       = !we;
      bus.WBs_BYTE_STB_i = bs;
      bus.WBs_CYC_i      = 1'b1;
      bus.WBs_STB_i      = 1'b1;
      for (int k = 0; k <= ack_at; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         noise = NCH'($urandom);
         if (sel) noise[ch] = 1'b0;
         if (k == ack_dly && ch >= 0) noise[ch] = 1'b1;
         bus.S_ACK_i = noise;
         err_clr     = clr_term && !slv && (k == ack_at);
         @(negedge clk);
         chk({tag, "/ack"}, 64'(bus.WBs_ACK_o), 64'(k == ack_at));
         chk({tag, "/s_cyc"}, 64'(bus.S_CYC_o), 64'((k == ack_at && !slv) ? '0 : exp_cyc));
         if (k == ack_at) chk({tag, "/dat"}, 64'(bus.WBs_DAT_o), 64'(exp_dat));
      end
      @(posedge clk); #1;
      bus.WBs_CYC_i = 1'b0;
      bus.WBs_STB_i = 1'b0;
      bus.WBs_WE_i  = 1'b0;
      bus.WBs_RD_i  = 1'b0;
      bus.S_ACK_i   = '0;
      err_clr       = 1'b0;
      if (!slv) begin
`ifdef WB_APERTURE_MUX_ERR_INTR_EN
         if (!m_valid) m_intr = 1'b1;
         else if (clr_term) m_intr = 1'b0;
`endif
         if (clr_term) begin
            m_valid = 1'b1; m_adr = a; m_cnt = 1;
         end else begin
            if (!m_valid) begin m_valid = 1'b1; m_adr = a; end
            if (m_cnt < 255) m_cnt++;
         end
      end
      @(negedge clk);
      chk_err(tag);
   endtask

   task automatic clear_err(input string tag);
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      m_valid = 1'b0; m_adr = '0; m_cnt = 0;
`ifdef WB_APERTURE_MUX_ERR_INTR_EN
      m_intr = 1'b0;
`endif
      @(negedge clk);
      chk_err(tag);
   endtask

   task automatic rand_access(input int n);
      int            pick = $urandom_range(0, NCH);
      logic [AW-1:0] a;
      int            dly;
      for (int i = 0; i < NCH; i++) sdat[i] = $urandom;
      if (pick < NCH) a = base[pick] | AW'($urandom_range(0, 4095));
      else            a = {5'($urandom_range(3, 17)), 12'($urandom)};
      dly = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO + 2));
      run_access(a, 1'($urandom), 4'($urandom), dly, 1'b0, $sformatf("rnd%0d", n));
   endtask

   initial begin
      m_valid = 1'b0; m_adr = '0; m_cnt = 0;
`ifdef WB_APERTURE_MUX_ERR_INTR_EN
      m_intr = 1'b0;
`endif
      sdat = '{32'h1111_0000, 32'h0000_00A5, 32'h2222_0002, 32'h3333_0003};
      // Hold reset with a live request to a mapped channel
      bus.WBs_ADR_i      = 17'h01004;
      bus.WBs_CYC_i      = 1'b1;
      bus.WBs_STB_i      = 1'b1;
      bus.WBs_RD_i       = 1'b1;
      bus.WBs_WE_i       = 1'b0;
      bus.WBs_BYTE_STB_i = 4'hF;
      bus.S_ACK_i        = '1;
      @(negedge clk);
      chk("rst/s_cyc", 64'(bus.S_CYC_o), 64'(0));
      chk("rst/ack", 64'(bus.WBs_ACK_o), 64'(0));
      chk("rst/dat", 64'(bus.WBs_DAT_o), 64'(32'h0000_00A5));
      chk_err("rst");
      bus.WBs_CYC_i = 1'b0; bus.WBs_STB_i = 1'b0; bus.WBs_RD_i = 1'b0;
      bus.S_ACK_i   = '0;
      @(negedge clk);
      rst_n = 1'b1;

      run_access(17'h01004, 1'b0, 4'hF, 2, 1'b0, "rd_ch1");
      run_access(17'h02000, 1'b1, 4'b0010, -1, 1'b0, "wr_b0rej");
      clear_err("clr1");
      run_access(17'h08000, 1'b0, 4'hF, -1, 1'b0, "unmap1");
      run_access(17'h09000, 1'b0, 4'hF, -1, 1'b0, "unmap2");
      run_access(17'h0A000, 1'b0, 4'hF, -1, 1'b1, "clr_in_term");
      run_access(17'h00FFC, 1'b0, 4'hF, TO, 1'b0, "ack_last");
      run_access(17'h12010, 1'b0, 4'hF, TO + 1, 1'b0, "ack_late");
      run_access(17'h01ABC, 1'b1, 4'b0001, 0, 1'b0, "wr_b0ok");
      run_access(17'h12000, 1'b1, 4'b0000, 3, 1'b0, "wr_ch3");
      run_access(17'h02004, 1'b1, 4'b1110, 1, 1'b0, "wr_b0rej2");

      for (int n = 0; n < 60; n++) rand_access(n);

      clear_err("clr2");
      for (int n = 0; n < 300; n++)
         run_access({5'($urandom_range(3, 17)), 12'($urandom)}, 1'b0, 4'hF, -1, 1'b0, "sat");
      chk("sat/cnt255", 64'(err_cnt), 64'(255));
      clear_err("clr3");
      run_access(17'h0C000, 1'b0, 4'hF, -1, 1'b0, "pre_rst");

      // Reset asserted in the third WAIT cycle of a read nobody answers
      @(posedge clk); #1;
      bus.WBs_ADR_i = 17'h00010; bus.WBs_RD_i = 1'b1; bus.WBs_WE_i = 1'b0;
      bus.WBs_CYC_i = 1'b1; bus.WBs_STB_i = 1'b1; bus.S_ACK_i = '0;
      @(negedge clk);
      chk("midrst/s_cyc_before", 64'(bus.S_CYC_o), 64'(4'b0001));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      m_valid = 1'b0; m_adr = '0; m_cnt = 0;
`ifdef WB_APERTURE_MUX_ERR_INTR_EN
      m_intr = 1'b0;
`endif
      chk("midrst/s_cyc", 64'(bus.S_CYC_o), 64'(0));
      chk("midrst/ack", 64'(bus.WBs_ACK_o), 64'(0));
      chk_err("midrst");
      @(negedge clk);
      chk("midrst/s_cyc_hold", 64'(bus.S_CYC_o), 64'(0));
      bus.WBs_CYC_i = 1'b0; bus.WBs_STB_i = 1'b0; bus.WBs_RD_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_access(17'h0B000, 1'b0, 4'hF, -1, 1'b0, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
